layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Parametrised controller sequencing an N-layer convolution pipeline: init load, buffer load, PE start, result write per layer.
- Successor to the fixed two-layer controller: supports NUM_LAYERS layers and a runtime layer count latched at start.
- Runs one layer at a time and counts windows per layer.
- Sits beside the datapath; per-layer control and status buses are NUM_LAYERS wide, with bit i belonging to layer i.

Parameters:
- NUM_LAYERS, 2, number of layers built into hardware (1..8).
- WIN_W, 16, width of the window counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- start  input  1  begin a run; sampled only in IDLE.
- layer_cnt  input  4  number of layers to run; latched when start is accepted.
- ld_buf_done  input  NUM_LAYERS  layer i input buffer loaded.
- pe_done  input  NUM_LAYERS  layer i PE computation finished.
- ctrl_done  input  NUM_LAYERS  layer i has no further windows.
- init_ld  output  NUM_LAYERS  one-cycle pulse: reset layer i address generators.
- ld_buf  output  NUM_LAYERS  level: load layer i buffer.
- pe_start  output  NUM_LAYERS  one-cycle pulse: start layer i PEs.
- mem_wr_en  output  NUM_LAYERS  one-cycle pulse: write layer i result to the next memory.
- cur_layer  output  3  index of the active layer.
- win_cnt  output  WIN_W  windows completed in the current layer.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at run end.

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE; all outputs 0; latched count=1. Applies mid-run; no pending pulse survives.
- Run length: latched count L = layer_cnt. If layer_cnt==0, L=1. If layer_cnt>NUM_LAYERS, L=NUM_LAYERS.
- IDLE: when start==1, cur_layer=0, latch L, go to INIT. start while busy is ignored.
- INIT: init_ld[cur_layer]=1 for 1 cycle; win_cnt cleared to 0; go to LOAD.
- LOAD: ld_buf[cur_layer]=1 held each cycle. In the cycle ld_buf_done[cur_layer]==1, ld_buf stays 1; go to START next edge.
- START: pe_start[cur_layer]=1 for 1 cycle; go to COMPUTE.
- COMPUTE: wait for pe_done[cur_layer]==1, then go to WRITE. pe_done is ignored in every other state, including START.
- WRITE: mem_wr_en[cur_layer]=1 for 1 cycle; win_cnt increments and saturates at all-ones. ctrl_done[cur_layer] is sampled in this cycle:
  - 0: go to LOAD (next window).
  - 1 and cur_layer==L-1: go to DONE.
  - 1 otherwise: cur_layer+1, go to INIT.
- DONE: done=1 for 1 cycle; go to IDLE. busy drops with done. start in the DONE cycle is ignored.
- Bus rule: only bit cur_layer of any per-layer output bus may be 1. Other bits are 0 at all times.
- Status bits of non-active layers are ignored.
- Minimum latency per window, with done inputs already high: LOAD(1)+START(1)+COMPUTE(1)+WRITE(1) = 4 cycles.
- Minimum single-layer, single-window run: start accepted to done = 6 cycles.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - Adds output cycle_cnt (32 bits), cleared when start is accepted.
  - Increments every cycle while busy; holds its value after done until the next start.
  - Reset clears it.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-run: rst=0 during COMPUTE of layer 1 -> next edge all outputs 0, busy=0. A later start with layer_cnt=1 runs normally from layer 0.
- NUM_LAYERS=2, layer_cnt=2, ctrl_done high on the 3rd WRITE of each layer -> exactly 3 mem_wr_en pulses on bit 0, then 3 on bit 1.
  - init_ld[1] pulses exactly once; win_cnt reads 3 before each layer switch; done pulses once.
- layer_cnt=0 and layer_cnt=9 (NUM_LAYERS=4) -> run covers 1 layer and 4 layers respectively.
- Immediate status (all done inputs tied high, one window) -> done pulse exactly 6 cycles after start accepted.
  - With SEQ_PERF_CNT_EN defined: cycle_cnt=6 after done.
- Spurious inputs: pe_done[0]=1 during LOAD, ld_buf_done[1]=1 while layer 0 is active, start=1 while busy -> no state change, no extra pulses.
- win_cnt saturation with WIN_W=2: 5 windows in one layer -> win_cnt reads 1,2,3,3,3 after each WRITE.

Source files
------------

// File: rtl/layer_sequencer.sv
// Layer-by-layer sequencer for an N-layer convolution pipeline: init, buffer load, PE start, result write.
// Optional cycle counter of the busy period when SEQ_PERF_CNT_EN is defined.
module layer_sequencer #(
  parameter int NUM_LAYERS = 2,
  parameter int WIN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            layer_cnt,
  input  logic [NUM_LAYERS-1:0] ld_buf_done,
  input  logic [NUM_LAYERS-1:0] pe_done,
  input  logic [NUM_LAYERS-1:0] ctrl_done,
  output logic [NUM_LAYERS-1:0] init_ld,
  output logic [NUM_LAYERS-1:0] ld_buf,
  output logic [NUM_LAYERS-1:0] pe_start,
  output logic [NUM_LAYERS-1:0] mem_wr_en,
  output logic [2:0]            cur_layer,
  output logic [WIN_W-1:0]      win_cnt,
  output logic                  busy,
  output logic                  done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt
`endif
);

  // state   | meaning
  // IDLE    | waiting for start
  // INIT    | init_ld pulse for the active layer, window count cleared
  // LOAD    | ld_buf held until the layer's buffer reports loaded
  // START   | pe_start pulse
  // COMPUTE | waiting for pe_done of the active layer
  // WRITE   | mem_wr_en pulse, decide next window / next layer / finish
  // DONE    | done pulse, back to IDLE
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_START, S_COMPUTE, S_WRITE, S_DONE
  } state_t;

  state_t     state;
  logic [2:0] last_layer;
  logic [3:0] run_len;

  function automatic logic [NUM_LAYERS-1:0] onehot(input logic [2:0] idx);
    logic [NUM_LAYERS-1:0] oh;
    for (int i = 0; i < NUM_LAYERS; i++) oh[i] = (idx == 3'(i));
    return oh;
  endfunction

  function automatic logic at_layer(input logic [NUM_LAYERS-1:0] bus, input logic [2:0] idx);
    return |(bus & onehot(idx));
  endfunction

  always_comb begin
    run_len = layer_cnt;
    if (layer_cnt == 4'd0) run_len = 4'd1;
    else if (layer_cnt > 4'(NUM_LAYERS)) run_len = 4'(NUM_LAYERS);
  end

  // Outputs are registered on entry to a state, so each pulse spans exactly that state's cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      init_ld    <= '0;
      ld_buf     <= '0;
      pe_start   <= '0;
      mem_wr_en  <= '0;
      cur_layer  <= '0;
      win_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      last_layer <= '0;
    end else begin
      init_ld   <= '0;
      pe_start  <= '0;
      mem_wr_en <= '0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_layer  <= '0;
            last_layer <= 3'(run_len - 4'd1);
            win_cnt    <= '0;
            init_ld    <= onehot(3'd0);
            busy       <= 1'b1;
            state      <= S_INIT;
          end
        end
        S_INIT: begin
          ld_buf <= onehot(cur_layer);
          state  <= S_LOAD;
        end
        S_LOAD: begin
          if (at_layer(ld_buf_done, cur_layer)) begin
            ld_buf   <= '0;
            pe_start <= onehot(cur_layer);
            state    <= S_START;
          end
        end
        S_START: state <= S_COMPUTE;
        S_COMPUTE: begin
          if (at_layer(pe_done, cur_layer)) begin
            mem_wr_en <= onehot(cur_layer);
            if (win_cnt != {WIN_W{1'b1}}) win_cnt <= win_cnt + 1'b1;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!at_layer(ctrl_done, cur_layer)) begin
            ld_buf <= onehot(cur_layer);
            state  <= S_LOAD;
          end else if (cur_layer == last_layer) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cur_layer <= cur_layer + 3'd1;
            init_ld   <= onehot(cur_layer + 3'd1);
            win_cnt   <= '0;
            state     <= S_INIT;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) cycle_cnt <= '0;
    else if (state == S_IDLE && start) cycle_cnt <= '0;
    else if (busy) cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: per-run expected cycle schedules built from the sequencing rules,
// checked every cycle, plus literal checks on pulse counts, latency and window counts.
module tb_layer_sequencer;
  localparam int NL = 4;
  localparam int WW = 2;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [3:0]    layer_cnt;
  logic [NL-1:0] ld_buf_done, pe_done, ctrl_done;
  logic [NL-1:0] init_ld, ld_buf, pe_start, mem_wr_en;
  logic [2:0]    cur_layer;
  logic [WW-1:0] win_cnt;
  logic          busy, done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]   cycle_cnt;
`endif

  layer_sequencer #(.NUM_LAYERS(NL), .WIN_W(WW)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_cnt(layer_cnt),
    .ld_buf_done(ld_buf_done), .pe_done(pe_done), .ctrl_done(ctrl_done),
    .init_ld(init_ld), .ld_buf(ld_buf), .pe_start(pe_start), .mem_wr_en(mem_wr_en),
    .cur_layer(cur_layer), .win_cnt(win_cnt), .busy(busy), .done(done)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst_v, start_v;
    logic [3:0]    lc;
    logic [NL-1:0] ldd, ped, cd;
    logic [NL-1:0] e_init, e_ld, e_pe, e_wr;
    logic [2:0]    e_layer;
    logic [WW-1:0] e_win;
    logic          e_busy, e_done;
  } vec_t;

  vec_t q[$];
  int   seg_end[$];
  int   n_vec = 0, n_err = 0;
  logic [2:0]    m_layer = '0;
  logic [WW-1:0] m_win = '0;

  int n_wr[NL], n_init[NL];
  int n_done, done_delay, acc_idx;
  int wr_win[$];

  function automatic logic [WW-1:0] sat(input int k);
    int mx = (1 << WW) - 1;
    return WW'((k > mx) ? mx : k);
  endfunction

  function automatic vec_t blank(input logic bsy, input bit spur);
    vec_t v;
    v.rst_v = 1'b1; v.start_v = bsy & spur; v.lc = 4'd0;
    v.ldd = spur ? '1 : '0; v.ped = spur ? '1 : '0; v.cd = spur ? '1 : '0;
    v.e_init = '0; v.e_ld = '0; v.e_pe = '0; v.e_wr = '0;
    v.e_layer = m_layer; v.e_win = m_win; v.e_busy = bsy; v.e_done = 1'b0;
    return v;
  endfunction

  // Expected schedule: INIT, then per window (dl+1) LOAD, START, (dp+1) COMPUTE, WRITE; then DONE.
  task automatic build_run(input int lc, input int nw[NL], input int dl, input int dp,
                           input bit spur, input int abort_layer);
    int L;
    vec_t v;
    logic [NL-1:0] b, o;
    L = (lc == 0) ? 1 : (lc > NL) ? NL : lc;
    v = blank(1'b0, 1'b0); v.start_v = 1'b1; v.lc = 4'(lc); q.push_back(v);
    for (int l = 0; l < L; l++) begin
      b = NL'(1) << l;
      o = spur ? ~b : '0;
      m_layer = 3'(l); m_win = '0;
      v = blank(1'b1, spur); v.e_init = b; q.push_back(v);
      for (int k = 1; k <= nw[l]; k++) begin
        for (int j = 0; j <= dl; j++) begin
          v = blank(1'b1, spur); v.e_ld = b; v.ldd = ((j == dl) ? b : '0) | o; q.push_back(v);
        end
        v = blank(1'b1, spur); v.e_pe = b; q.push_back(v);
        for (int j = 0; j <= dp; j++) begin
          v = blank(1'b1, spur); v.ped = ((j == dp) ? b : '0) | o;
          if (l == abort_layer) begin
            v.rst_v = 1'b0; q.push_back(v);
            m_layer = '0; m_win = '0;
            q.push_back(blank(1'b0, 1'b0));
            seg_end.push_back(q.size());
            return;
          end
          q.push_back(v);
        end
        m_win = sat(k);
        v = blank(1'b1, spur); v.e_wr = b; v.cd = ((k == nw[l]) ? b : '0) | o; q.push_back(v);
      end
    end
    v = blank(1'b1, spur); v.e_done = 1'b1; q.push_back(v);
    q.push_back(blank(1'b0, 1'b0));
    seg_end.push_back(q.size());
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    n_vec++;
    if (init_ld !== v.e_init || ld_buf !== v.e_ld || pe_start !== v.e_pe || mem_wr_en !== v.e_wr ||
        cur_layer !== v.e_layer || win_cnt !== v.e_win || busy !== v.e_busy || done !== v.e_done) begin
      n_err++;
      $display("FAIL cycle %0d: got init=%b ld=%b pe=%b wr=%b layer=%0d win=%0d busy=%b done=%b, expected init=%b ld=%b pe=%b wr=%b layer=%0d win=%0d busy=%b done=%b",
               i, init_ld, ld_buf, pe_start, mem_wr_en, cur_layer, win_cnt, busy, done,
               v.e_init, v.e_ld, v.e_pe, v.e_wr, v.e_layer, v.e_win, v.e_busy, v.e_done);
    end
  endtask

  task automatic clear_obs();
    for (int b = 0; b < NL; b++) begin n_wr[b] = 0; n_init[b] = 0; end
    n_done = 0; done_delay = -1; acc_idx = 0;
    wr_win.delete();
  endtask

  task automatic run_literals(input int r);
    int tot_init = 0, tot_wr = 0;
    for (int b = 0; b < NL; b++) begin tot_init += n_init[b]; tot_wr += n_wr[b]; end
    case (r)
      0: begin
        lit("two_layer_wr0", n_wr[0], 3);
        lit("two_layer_wr1", n_wr[1], 3);
        lit("two_layer_init1", n_init[1], 1);
        lit("two_layer_done", n_done, 1);
        lit("win_before_switch0", (wr_win.size() > 2) ? wr_win[2] : -1, 3);
        lit("win_before_switch1", (wr_win.size() > 5) ? wr_win[5] : -1, 3);
      end
      1: lit("abort_no_done", n_done, 0);
      2: begin
        lit("immediate_latency", done_delay, 6);
`ifdef SEQ_PERF_CNT_EN
        lit("cycle_cnt", int'(cycle_cnt), 6);
`endif
      end
      3: lit("lc0_layers", tot_init, 1);
      4: begin
        lit("lc9_layers", tot_init, 4);
        lit("lc9_init3", n_init[3], 1);
      end
      5: begin
        lit("spurious_done", n_done, 1);
        lit("spurious_writes", tot_wr, 3);
      end
      6: begin
        lit("sat_writes", wr_win.size(), 5);
        for (int k = 0; k < 5; k++)
          lit($sformatf("sat_win%0d", k), (k < wr_win.size()) ? wr_win[k] : -1, (k < 2) ? k + 1 : 3);
      end
      default: ;
    endcase
  endtask

  initial begin
    int r;
    rst = 1'b0; start = 1'b0; layer_cnt = 4'd0;
    ld_buf_done = '0; pe_done = '0; ctrl_done = '0;
    build_run(2, '{3, 3, 0, 0}, 1, 2, 1'b0, -1);
    build_run(2, '{2, 2, 0, 0}, 0, 1, 1'b0, 1);
    build_run(1, '{1, 0, 0, 0}, 0, 0, 1'b0, -1);
    build_run(0, '{2, 1, 1, 1}, 0, 0, 1'b0, -1);
    build_run(9, '{1, 2, 1, 1}, 1, 0, 1'b0, -1);
    build_run(2, '{2, 1, 0, 0}, 2, 1, 1'b1, -1);
    build_run(1, '{5, 0, 0, 0}, 0, 1, 1'b0, -1);
    repeat (2) @(posedge clk);
    clear_obs();
    r = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      check_vec(i, q[i]);
      for (int b = 0; b < NL; b++) begin
        if (mem_wr_en[b]) n_wr[b]++;
        if (init_ld[b]) n_init[b]++;
      end
      if (|mem_wr_en) wr_win.push_back(int'(win_cnt));
      if (done) begin n_done++; done_delay = i - acc_idx; end
      if (q[i].start_v && !q[i].e_busy) acc_idx = i;
      rst = q[i].rst_v; start = q[i].start_v; layer_cnt = q[i].lc;
      ld_buf_done = q[i].ldd; pe_done = q[i].ped; ctrl_done = q[i].cd;
      if (r < seg_end.size() && i == seg_end[r] - 1) begin
        run_literals(r);
        clear_obs();
        r++;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
